mul_sequencer: RTL and testbench

MUL_SEQUENCER -- requirements
Module: mul_sequencer

---
 rtl/mul_seq_pkg.sv | 42 ++++
 rtl/mul_step_counter.sv | 35 +++
 rtl/mul_sequencer.sv | 171 +++++++++++++++++
 tb/tb_mul_sequencer.sv | 179 +++++++++++++++++
 4 files changed

// File: rtl/mul_seq_pkg.sv
// Shared types and defaults for the H6 multiply sequencer.
package mul_seq_pkg;

  localparam int DEF_STEPS  = 16;
  localparam int DEF_SETTLE = 2;

  typedef enum logic [3:0] {
    S_IDLE   = 4'd0,
    S_LOADA  = 4'd1,
    S_LOADB  = 4'd2,
    S_RUN    = 4'd3,
    S_SETTLE = 4'd4,
    S_RDA    = 4'd5,
    S_RDQ    = 4'd6,
    S_DONE   = 4'd7,
    S_CLR    = 4'd8
  } mul_state_e;

  // One registered copy of every strobe driven towards the H6 datapath.
  typedef struct packed {
    logic mul1;
    logic mul2_1;
    logic mul2_2;
    logic rst;
    logic in_two;
    logic in_three;
    logic in_four;
    logic in_qlk;
    logic als_a;
    logic als_q;
    logic busy;
    logic done;
  } mul_out_t;

  // Counter width able to hold both STEPS-1 and SETTLE-1.
  function automatic int cnt_width(input int steps, input int settle);
    int m;
    m = (steps > settle) ? steps : settle;
    return (m <= 2) ? 1 : $clog2(m);
  endfunction

endpackage

// File: rtl/mul_step_counter.sv
// Loadable down-counter for the RUN step and SETTLE cycle budgets.
module mul_step_counter #(
  parameter int W = 4
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         load,
  input  logic [W-1:0] load_val,
  input  logic         dec,
  output logic         tc
);

  logic [W-1:0] count_q, count_d;

  // Load wins over decrement; the count saturates at zero.
  always_comb begin
    count_d = count_q;
    if (load) begin
      count_d = load_val;
    end else if (dec && (count_q != '0)) begin
      count_d = count_q - W'(1);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

  assign tc = (count_q == '0);

endmodule

// File: rtl/mul_sequencer.sv
// Control sequencer for the H6 shift/add multiplier: load A, load B, step,
// settle, read A and Q, with abort-to-clear and registered strobes.
module mul_sequencer
  import mul_seq_pkg::*;
#(
  parameter int STEPS  = DEF_STEPS,
  parameter int SETTLE = DEF_SETTLE
) (
  input  logic CLK_50,
  input  logic Rst_n,
  input  logic start,
  input  logic b_sel,
  input  logic abort,
  input  logic alu_carryOut,
  input  logic alu_overflowOut,
  output logic MUL1,
  output logic MUL2_1,
  output logic MUL2_2,
  output logic Rst,
  output logic inTWO,
  output logic inTHREE,
  output logic inFOUR,
  output logic inQLK,
  output logic ALS_H6_a,
  output logic ALS_H6_q,
  output logic busy,
  output logic done,
  output logic cf,
  output logic vf
);

  localparam int CW = cnt_width(STEPS, SETTLE);
  localparam logic [CW-1:0] RUN_LOAD    = CW'(STEPS - 1);
  localparam logic [CW-1:0] SETTLE_LOAD = CW'((SETTLE > 0) ? SETTLE - 1 : 0);

  mul_state_e    state_q, state_d;
  mul_out_t      out_q, out_d;
  logic          bsel_q, bsel_d;
  logic          cf_q, cf_d;
  logic          vf_q, vf_d;
  logic          cnt_load, cnt_dec, cnt_tc;
  logic [CW-1:0] cnt_load_val;

  mul_step_counter #(.W(CW)) u_step_cnt (
    .clk      (CLK_50),
    .rst_n    (Rst_n),
    .load     (cnt_load),
    .load_val (cnt_load_val),
    .dec      (cnt_dec),
    .tc       (cnt_tc)
  );

  // Next state. The step counter holds remaining steps in RUN and is
  // decremented on each low inQLK phase; abort overrides everything.
  always_comb begin
    state_d      = state_q;
    bsel_d       = bsel_q;
    cf_d         = cf_q;
    vf_d         = vf_q;
    cnt_load     = 1'b0;
    cnt_load_val = RUN_LOAD;
    cnt_dec      = 1'b0;
    if (abort && (state_q != S_IDLE)) begin
      state_d = S_CLR;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (start && !abort) begin
            state_d = S_LOADA;
            bsel_d  = b_sel;
          end
        end
        S_LOADA: state_d = S_LOADB;
        S_LOADB: begin
          state_d      = S_RUN;
          cnt_load     = 1'b1;
          cnt_load_val = RUN_LOAD;
        end
        S_RUN: begin
          if (!out_q.in_qlk) begin
            cnt_dec = 1'b1;
            if (cnt_tc) begin
              if (SETTLE > 0) begin
                state_d      = S_SETTLE;
                cnt_load     = 1'b1;
                cnt_load_val = SETTLE_LOAD;
              end else begin
                state_d = S_RDA;
              end
            end
          end
        end
        S_SETTLE: begin
          cnt_dec = 1'b1;
          if (cnt_tc) begin
            state_d = S_RDA;
          end
        end
        S_RDA: begin
          state_d = S_RDQ;
          cf_d    = alu_carryOut;
          vf_d    = alu_overflowOut;
        end
        S_RDQ:   state_d = S_DONE;
        S_DONE:  state_d = S_IDLE;
        S_CLR:   state_d = S_IDLE;
        default: state_d = S_IDLE;
      endcase
    end
  end

  // Strobes are decoded from the next state so they line up with it once
  // registered. inQLK starts high on RUN entry and toggles every cycle.
  always_comb begin
    out_d      = '0;
    out_d.busy = (state_d != S_IDLE);
    case (state_d)
      S_LOADA: begin
        out_d.mul1   = 1'b1;
        out_d.in_two = 1'b1;
      end
      S_LOADB: begin
        out_d.in_three = 1'b1;
        out_d.mul2_1   = !bsel_d;
        out_d.mul2_2   = bsel_d;
      end
      S_RUN: begin
        out_d.in_four = 1'b1;
        out_d.in_qlk  = (state_q != S_RUN) || !out_q.in_qlk;
      end
      S_SETTLE: out_d.in_four = 1'b1;
      S_RDA:    out_d.als_a   = 1'b1;
      S_RDQ:    out_d.als_q   = 1'b1;
      S_DONE:   out_d.done    = 1'b1;
      S_CLR:    out_d.rst     = 1'b1;
      default:  out_d.busy    = 1'b0;
    endcase
  end

  always_ff @(posedge CLK_50 or negedge Rst_n) begin
    if (!Rst_n) begin
      state_q <= S_IDLE;
      out_q   <= '0;
      bsel_q  <= 1'b0;
      cf_q    <= 1'b0;
      vf_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      out_q   <= out_d;
      bsel_q  <= bsel_d;
      cf_q    <= cf_d;
      vf_q    <= vf_d;
    end
  end

  assign MUL1     = out_q.mul1;
  assign MUL2_1   = out_q.mul2_1;
  assign MUL2_2   = out_q.mul2_2;
  assign Rst      = out_q.rst;
  assign inTWO    = out_q.in_two;
  assign inTHREE  = out_q.in_three;
  assign inFOUR   = out_q.in_four;
  assign inQLK    = out_q.in_qlk;
  assign ALS_H6_a = out_q.als_a;
  assign ALS_H6_q = out_q.als_q;
  assign busy     = out_q.busy;
  assign done     = out_q.done;
  assign cf       = cf_q;
  assign vf       = vf_q;

endmodule

// File: tb/tb_mul_sequencer.sv
// Directed bench for mul_sequencer: default build plus a STEPS=4/SETTLE=1 build.
module tb_mul_sequencer;

  logic clk = 1'b0;
  logic rst_n, start, start2, b_sel, abort, alu_carry, alu_ovf;
  logic a_mul1, a_mul2_1, a_mul2_2, a_rst, a_in2, a_in3, a_in4, a_qlk;
  logic a_als_a, a_als_q, a_busy, a_done, a_cf, a_vf;
  logic b_mul1, b_mul2_1, b_mul2_2, b_rst, b_in2, b_in3, b_in4, b_qlk;
  logic b_als_a, b_als_q, b_busy, b_done, b_cf, b_vf;
  logic [11:0] vec_a, vec_b;
  int checks = 0;
  int errors = 0;

  always #10 clk = ~clk;

  mul_sequencer dut_a (
    .CLK_50(clk), .Rst_n(rst_n), .start(start), .b_sel(b_sel), .abort(abort),
    .alu_carryOut(alu_carry), .alu_overflowOut(alu_ovf),
    .MUL1(a_mul1), .MUL2_1(a_mul2_1), .MUL2_2(a_mul2_2), .Rst(a_rst),
    .inTWO(a_in2), .inTHREE(a_in3), .inFOUR(a_in4), .inQLK(a_qlk),
    .ALS_H6_a(a_als_a), .ALS_H6_q(a_als_q), .busy(a_busy), .done(a_done),
    .cf(a_cf), .vf(a_vf)
  );

  mul_sequencer #(.STEPS(4), .SETTLE(1)) dut_b (
    .CLK_50(clk), .Rst_n(rst_n), .start(start2), .b_sel(b_sel), .abort(abort),
    .alu_carryOut(alu_carry), .alu_overflowOut(alu_ovf),
    .MUL1(b_mul1), .MUL2_1(b_mul2_1), .MUL2_2(b_mul2_2), .Rst(b_rst),
    .inTWO(b_in2), .inTHREE(b_in3), .inFOUR(b_in4), .inQLK(b_qlk),
    .ALS_H6_a(b_als_a), .ALS_H6_q(b_als_q), .busy(b_busy), .done(b_done),
    .cf(b_cf), .vf(b_vf)
  );

  assign vec_a = {a_mul1, a_mul2_1, a_mul2_2, a_rst, a_in2, a_in3, a_in4, a_qlk,
                  a_als_a, a_als_q, a_busy, a_done};
  assign vec_b = {b_mul1, b_mul2_1, b_mul2_2, b_rst, b_in2, b_in3, b_in4, b_qlk,
                  b_als_a, b_als_q, b_busy, b_done};

  // Expected strobe vector for cycle c after the start edge (cycle table).
  function automatic logic [11:0] exp_vec(input int c, input bit bsel,
                                          input int steps, input int settle);
    int run_hi, rda, rdq, dn;
    logic m1, m21, m22, i2, i3, i4, qlk, aa, aq, bz, dd;
    run_hi = 2 + 2 * steps;
    rda    = run_hi + settle + 1;
    rdq    = rda + 1;
    dn     = rda + 2;
    m1  = (c == 1);
    i2  = m1;
    i3  = (c == 2);
    m21 = i3 && !bsel;
    m22 = i3 && bsel;
    i4  = (c >= 3) && (c < rda);
    qlk = (c >= 3) && (c <= run_hi) && (((c - 3) % 2) == 0);
    aa  = (c == rda);
    aq  = (c == rdq);
    dd  = (c == dn);
    bz  = (c >= 1) && (c <= dn);
    return {m1, m21, m22, 1'b0, i2, i3, i4, qlk, aa, aq, bz, dd};
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // One full multiply; b_sel is flipped after the start edge to prove it was latched.
  task automatic run_full(input int id, input bit bsel, input bit use2,
                          input int ign_at, input bit cy, input bit ov);
    int pa, pb;
    pa = 0;
    pb = 0;
    alu_carry = cy;
    alu_ovf   = ov;
    b_sel     = bsel;
    start     = 1'b1;
    start2    = use2;
    tick();
    start  = 1'b0;
    start2 = 1'b0;
    for (int c = 1; c <= 41; c++) begin
      if (c == 1) b_sel = ~bsel;
      check($sformatf("run%0d_a_c%0d", id, c), 32'(vec_a), 32'(exp_vec(c, bsel, 16, 2)));
      if (use2)
        check($sformatf("run%0d_b_c%0d", id, c), 32'(vec_b), 32'(exp_vec(c, bsel, 4, 1)));
      pa += int'(a_qlk);
      pb += int'(b_qlk);
      start = (c == ign_at);
      tick();
    end
    start = 1'b0;
    check($sformatf("run%0d_a_pulses", id), 32'(pa), 32'd16);
    check($sformatf("run%0d_a_flags", id), 32'({a_cf, a_vf}), 32'({cy, ov}));
    if (use2) begin
      check($sformatf("run%0d_b_pulses", id), 32'(pb), 32'd4);
      check($sformatf("run%0d_b_flags", id), 32'({b_cf, b_vf}), 32'({cy, ov}));
    end
  endtask

  initial begin
    int p;
    rst_n = 1'b0; start = 1'b0; start2 = 1'b0; b_sel = 1'b0; abort = 1'b0;
    alu_carry = 1'b0; alu_ovf = 1'b0;
    tick();
    tick();
    check("reset_a_vec", 32'(vec_a), 32'd0);
    check("reset_b_vec", 32'(vec_b), 32'd0);
    check("reset_a_flags", 32'({a_cf, a_vf}), 32'd0);

    // Release mid-cycle; the very next edge must accept start.
    rst_n = 1'b1;
    run_full(1, 1'b0, 1'b1, 0, 1'b0, 1'b1);
    run_full(2, 1'b1, 1'b1, 20, 1'b1, 1'b0);
    repeat (5) tick();
    check("idle_hold_flags", 32'({a_cf, a_vf}), 32'({1'b1, 1'b0}));
    check("idle_hold_vec", 32'(vec_a), 32'd0);

    // Abort right after the 5th inQLK pulse.
    alu_carry = 1'b0; alu_ovf = 1'b1; b_sel = 1'b0;
    start = 1'b1;
    tick();
    start = 1'b0;
    p = 0;
    for (int c = 1; c <= 11; c++) begin
      p += int'(a_qlk);
      if (c < 11) tick();
    end
    check("abort_pulse5_high", 32'(a_qlk), 32'd1);
    check("abort_pulse_count", 32'(p), 32'd5);
    abort = 1'b1;
    tick();
    abort = 1'b0;
    check("abort_clr_vec", 32'(vec_a), 32'h102);
    tick();
    check("abort_idle_vec", 32'(vec_a), 32'd0);
    for (int i = 0; i < 5; i++) begin
      tick();
      check($sformatf("abort_no_done_%0d", i), 32'(vec_a), 32'd0);
    end
    check("abort_flags_kept", 32'({a_cf, a_vf}), 32'({1'b1, 1'b0}));

    // abort wins over start in IDLE; abort alone in IDLE does nothing.
    start = 1'b1; abort = 1'b1;
    tick();
    start = 1'b0; abort = 1'b0;
    check("idle_abort_start_0", 32'(vec_a), 32'd0);
    tick();
    check("idle_abort_start_1", 32'(vec_a), 32'd0);
    abort = 1'b1;
    tick();
    abort = 1'b0;
    check("idle_abort_only", 32'(vec_a), 32'd0);

    // Asynchronous reset in the middle of RUN.
    start = 1'b1;
    tick();
    start = 1'b0;
    repeat (9) tick();
    check("pre_reset_c10", 32'(vec_a), 32'(exp_vec(10, 1'b0, 16, 2)));
    #3 rst_n = 1'b0;
    #1;
    check("async_reset_vec", 32'(vec_a), 32'd0);
    check("async_reset_flags", 32'({a_cf, a_vf}), 32'd0);
    rst_n = 1'b1;
    run_full(3, 1'b0, 1'b0, 0, 1'b1, 1'b1);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
